// File: rtl/msg_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_ram_pkg
// Purpose  : Shared constants and FSM encoding for the message RAM write path.
//            The same defaults size the RAM instance, so that the writer and
//            the memory always agree on width, depth and address bits.
// Contents : MSG_WIDTH_DEF, MEM_HEIGHT_DEF, ADDR_DEF, wr_state_t
// Revision : 1.0 - initial release
// ============================================================================
package msg_ram_pkg;

  localparam int MSG_WIDTH_DEF  = 16;
  localparam int MEM_HEIGHT_DEF = 32;
  localparam int ADDR_DEF       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } wr_state_t;

endpackage : msg_ram_pkg
`default_nettype wire

// File: rtl/msg_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : msg_ram_writer
// Purpose  : Write-side controller for the message RAM. Accepts messages on a
//            valid/ready stream and writes them to consecutive addresses from
//            0, one word per clock, until s_last or the RAM is full.
// Ports    : clk, rst (async, active-low)
//            start                       - begin a new frame at address 0
//            s_valid/s_data/s_last/s_ready - message stream (s_ready is comb)
//            wr_en/wr_addr/wr_data       - registered RAM write port
//            count                       - words written in current frame
//            frame_done                  - 1-cycle pulse with the last write
//            truncated                   - sticky, frame ended on full RAM
// Revision : 1.0 - initial release
// ============================================================================
module msg_ram_writer
  import msg_ram_pkg::*;
#(
  parameter int MSG_WIDTH  = MSG_WIDTH_DEF,
  parameter int MEM_HEIGHT = MEM_HEIGHT_DEF,
  parameter int ADDR       = ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic [MSG_WIDTH-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 wr_en,
  output logic [ADDR-1:0]      wr_addr,
  output logic [MSG_WIDTH-1:0] wr_data,
  output logic [ADDR:0]        count,
  output logic                 frame_done,
  output logic                 truncated
);

  localparam logic [ADDR:0] C_FULL = (ADDR+1)'(MEM_HEIGHT);
  localparam logic [ADDR:0] C_ONE  = (ADDR+1)'(1);

  wr_state_t     state;
  wr_state_t     state_nxt;
  logic          accept;
  logic [ADDR:0] count_inc;
  logic          hit_full;
  logic          frame_end;

  // The word count doubles as the write pointer: within a frame the next
  // address is always the number of words already written, and the frame
  // ends before the count can pass MEM_HEIGHT, so the pointer never wraps.
  assign accept    = s_valid && s_ready;
  assign count_inc = count + C_ONE;
  assign hit_full  = (count_inc == C_FULL);
  assign frame_end = accept && (s_last || hit_full);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. start restarts the frame from any state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (frame_end) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. start masks ready so a coincident beat is not taken.
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready = (state == FILL) && !start;
  end

  // --------------------------------------------------------------------------
  // Write port, count and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      count      <= '0;
      frame_done <= 1'b0;
      truncated  <= 1'b0;
    end else begin
      wr_en      <= accept;
      frame_done <= frame_end;
      if (start) begin
        count     <= '0;
        truncated <= 1'b0;
      end else if (accept) begin
        wr_addr <= count[ADDR-1:0];
        wr_data <= s_data;
        count   <= count_inc;
        if (hit_full && !s_last) begin
          truncated <= 1'b1;
        end
      end
    end
  end

endmodule : msg_ram_writer
`default_nettype wire

// File: tb/tb_msg_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_ram_writer
// Purpose  : Self-checking bench for msg_ram_writer. The driver keeps a small
//            reference model of the frame and pushes each expected RAM write
//            into a queue; a negedge monitor pops and compares every write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_ram_writer;

  localparam int MW = 16;
  localparam int MH = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
    logic [AW:0]   cnt;
    logic          fd;
    logic          tr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [MW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_data;
  logic [AW:0]   count;
  logic          frame_done;
  logic          truncated;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int writes_exp  = 0;

  exp_t exp_q[$];

  // reference model: 0 idle, 1 fill, 2 done
  int          m_state = 0;
  logic [AW:0] m_count = '0;
  logic        m_trunc = 1'b0;

  msg_ram_writer #(.MSG_WIDTH(MW), .MEM_HEIGHT(MH), .ADDR(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .frame_done(frame_done),
    .truncated (truncated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && frame_done && !wr_en) begin
      checks++;
      errors++;
      $display("FAIL frame_done_without_wr_en at %0t", $time);
    end
    if (rst && wr_en) begin
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected at %0t",
                 wr_addr, wr_data, $time);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a = '{addr: wr_addr, data: wr_data, cnt: count, fd: frame_done, tr: truncated};
        if (a !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=0x%0h cnt=%0d fd=%0b tr=%0b, expected addr=%0d data=0x%0h cnt=%0d fd=%0b tr=%0b",
                   a.addr, a.data, a.cnt, a.fd, a.tr, e.addr, e.data, e.cnt, e.fd, e.tr);
        end
      end
    end
  end

  // One clock of stimulus. Called at posedge+1; returns at next posedge+1.
  task automatic step(input logic v, input logic [MW-1:0] d, input logic l, input logic st);
    logic exp_ready;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    start   = st;
    #1;
    exp_ready = (m_state == 1) && !st;
    chk("s_ready", 32'(s_ready), 32'(exp_ready));
    chk("count", 32'(count), 32'(m_count));
    chk("truncated", 32'(truncated), 32'(m_trunc));
    if (st) begin
      m_state = 1;
      m_count = '0;
      m_trunc = 1'b0;
    end else if (v && exp_ready) begin
      exp_t e;
      logic full;
      full    = (m_count + 1) == MH;
      e.addr  = m_count[AW-1:0];
      e.data  = d;
      e.cnt   = m_count + 1;
      e.fd    = l || full;
      e.tr    = full && !l;
      m_count = m_count + 1;
      if (e.tr) m_trunc = 1'b1;
      if (e.fd) m_state = 2;
      exp_q.push_back(e);
      writes_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] gaps;
    gaps = 20'b1011_0011_1010_1101_0110;

    // reset state
    #3;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_truncated", 32'(truncated), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // short frame of three words
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b1, 1'b0);
    idle(2);

    // overflow: 40 beats, no s_last, truncate after 32
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
    idle(2);

    // s_last exactly on the 32nd word
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b1, 16'(16'h2000 + i), (i == 31), 1'b0);
    idle(2);

    // valid gaps
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(gaps[i], 16'(16'h3000 + i), 1'b0, 1'b0);
    idle(1);

    // start coincident with a beat after 5 writes
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
    step(1'b1, 16'h0BAD, 1'b0, 1'b1);
    step(1'b1, 16'h00C0, 1'b0, 1'b0);
    step(1'b1, 16'h00C1, 1'b1, 1'b0);
    idle(2);

    // async reset mid-frame after 10 writes
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'h5555;
    #1;
    chk("pre_rst_count", 32'(count), 10);
    rst = 1'b0;
    #1;
    chk("arst_s_ready", 32'(s_ready), 0);
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_wr_addr", 32'(wr_addr), 0);
    chk("arst_wr_data", 32'(wr_data), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    chk("arst_truncated", 32'(truncated), 0);
    m_state = 0;
    m_count = '0;
    m_trunc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 16'h5555, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h6001, 1'b1, 1'b0);
    idle(3);

    chk("pending_writes", 32'(exp_q.size()), 0);
    chk("total_writes", 32'(writes_seen), 32'(writes_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_msg_ram_writer
`default_nettype wire

// File: doc/msg_ram_writer.md
# msg_ram_writer

Write-side controller for the message RAM. It accepts a stream of `MSG_WIDTH`-bit messages over a valid/ready handshake and drives the RAM write port with sequential addresses starting at 0. Each frame starts on `start` and ends on `s_last` or when the memory is full. The block sits between the message source (parser/feed) and the RAM's `we`/`w_addr`/`data_in` port, and reports fill count, frame completion and truncation.

## Interface
- `MSG_WIDTH`, 16, message/RAM word width
- `MEM_HEIGHT`, 32, RAM depth in words; must satisfy `MEM_HEIGHT <= 2**ADDR`
- `ADDR`, 5, RAM address width

Ports:
- `clk`  in  1  single clock. Logic is posedge; outputs are registered.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a new frame from address 0.
- `s_valid`  in  1  source has a message.
- `s_data`  in  MSG_WIDTH  message payload.
- `s_last`  in  1  qualifies the final message of a frame.
- `s_ready`  out  1  block accepts the message this cycle (combinational).
- `wr_en`  out  1  RAM write enable; connects to RAM `we`.
- `wr_addr`  out  ADDR  RAM write address; connects to RAM `w_addr`.
- `wr_data`  out  MSG_WIDTH  RAM write data; connects to RAM `data_in`.
- `count`  out  ADDR+1  number of words written in the current frame.
- `frame_done`  out  1  one-cycle pulse; the frame is complete.
- `truncated`  out  1  sticky; the frame hit `MEM_HEIGHT` without `s_last`.

## Operation
- FSM states: IDLE, FILL, DONE.
- Reset state: IDLE.
  - `s_ready`, `wr_en`, `frame_done`, `truncated` = 0.
  - `wr_addr`, `wr_data`, `count` = 0.
  - Internal address pointer = 0.
- `s_ready` = (state == FILL) && !`start`.
- Handshake rules:
  - A beat is accepted when `s_valid && s_ready`.
  - The source holds `s_data`/`s_last` stable while `s_valid && !s_ready`.
- `start`, in any state, moves the FSM to FILL on the next edge. It also clears the pointer, `count` and `truncated`. It wins over a coincident beat: that beat is not accepted.
- On an accepted beat, at the next edge:
  - `wr_en` = 1, `wr_addr` = pointer, `wr_data` = `s_data`.
  - pointer += 1, `count` += 1.
- If the accepted beat has `s_last`=1, or the new `count` == `MEM_HEIGHT`:
  - The FSM goes to DONE.
  - `frame_done` = 1 in the same cycle as that final `wr_en`.
  - If the end was caused by `count` reaching `MEM_HEIGHT` and `s_last`=0, `truncated` is set.
- `s_last` on the `MEM_HEIGHT`-th word: normal completion, `truncated` stays 0.
- `wr_en` and `frame_done` are single-cycle pulses. `wr_en` is 0 in every cycle without an accepted beat in the preceding cycle.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.
- In DONE, `s_ready`=0. `s_valid` is backpressured and is not an error. The FSM stays in DONE until `start`.
- IDLE behaves like DONE without `frame_done`; it is left only by `start`.
- The pointer never wraps within a frame. It stops at `MEM_HEIGHT`.
- An async reset mid-frame returns everything to reset values immediately. No partial write is emitted.

## Timing
- Latency from accepted beat to `wr_en` high is 1 clk.
- The RAM samples on negedge. `wr_*` are registered on posedge, so they are stable for half a cycle before the RAM's capture edge.
- Throughput is 1 word/clk in FILL.
- Start-to-first-accept: `start` at edge N. `s_ready` = 1 from cycle N+1.
- `count` reflects the write visible on `wr_en` in the same cycle.

## Structure
- Shared package `msg_ram_pkg` holds:
  - Defaults `MSG_WIDTH`=16, `MEM_HEIGHT`=32, `ADDR`=5.
  - The FSM state encoding `wr_state_t` = {IDLE, FILL, DONE}. The same constants are used by the RAM instantiation.
- Single module, no sub-module. The FSM and the pointer/count register are small enough to stay flat.

## Test plan
- Reset, then `start`, then 3 beats 0x0011, 0x0022, 0x0033 (last on 3rd):
  - `wr_addr` 0,1,2 with matching `wr_data`, one cycle after each accept.
  - `frame_done` with the 3rd write; `count`=3; `truncated`=0; `s_ready`=0 afterwards.
- `start`, then 40 back-to-back beats, no `s_last`:
  - Exactly 32 writes, addr 0..31.
  - `frame_done` + `truncated`=1 on write 31; `count`=32.
  - Beats 33..40 backpressured.
- `s_last` on the 32nd beat: `frame_done`=1, `truncated`=0, `count`=32.
- Random `s_valid` gaps during FILL: `wr_en` only after accepts, addresses contiguous, no duplicates.
- `start` coincident with `s_valid` in FILL after 5 writes:
  - That beat is not written.
  - `count`=0 next cycle; next accepted beat written to addr 0.
- Async `rst` low mid-frame (after 10 writes):
  - All outputs return to 0 immediately; state IDLE.
  - `s_ready`=0 until the next `start`.
